// File: rtl/mode_switch_sequencer_pkg.sv
// Shared video mode codes and the legality check used when a requested mode is captured.
package mode_switch_sequencer_pkg;

  localparam logic [7:0] MODE_1080p      = 8'h01;
  localparam logic [7:0] MODE_1080i      = 8'h02;
  localparam logic [7:0] MODE_720p       = 8'h03;
  localparam logic [7:0] MODE_480p       = 8'h04;
  localparam logic [7:0] MODE_480i       = 8'h05;
  localparam logic [7:0] DEFAULT_FB_MODE = MODE_480p;

  function automatic logic mode_is_valid(input logic [7:0] code);
    return (code == MODE_1080p) || (code == MODE_1080i) || (code == MODE_720p) ||
           (code == MODE_480p)  || (code == MODE_480i);
  endfunction

  // Unknown codes fall back to the safe framebuffer mode.
  function automatic logic [7:0] legalize_mode(input logic [7:0] code);
    return mode_is_valid(code) ? code : DEFAULT_FB_MODE;
  endfunction

endpackage

// File: rtl/mode_switch_sequencer_timer.sv
// sequencer_timer: clear/enable up-counter with a terminal-value compare.
module sequencer_timer #(
  parameter int CNT_W = 21
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] term_val,
  output logic             at_term
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end
  end

  assign at_term = (count == term_val);

endmodule

// File: rtl/mode_switch_sequencer.sv
// Frame-aligned video mode switch: blank, reprogram PLL via req/ack, wait lock + settle, re-enable.
// Optional IDLE debounce of mode requests when SEQ_DEBOUNCE_EN is defined.
import mode_switch_sequencer_pkg::*;

module mode_switch_sequencer #(
  parameter int SETTLE_CYCLES = 1024,
  parameter int LOCK_TIMEOUT  = 1048576,
  parameter int CNT_W         = 21
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] config_data,
  input  logic       config_changed,
  input  logic       frame_end,
  input  logic       pll_reconfig_ack,
  input  logic       pll_locked,
  output logic       pll_reconfig_req,
  output logic [7:0] pll_mode,
  output logic [7:0] active_mode,
  output logic       video_enable,
  output logic       busy,
  output logic       lock_timeout
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_FRAME,
    ST_REQ,
    ST_WAIT_LOCK,
    ST_SETTLE
  } state_t;

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [7:0]       pending_mode_q;
  logic             lt_d;
  logic             tmr_clear, tmr_enable, tmr_at_term;
  logic [CNT_W-1:0] tmr_term;

  sequencer_timer #(.CNT_W(CNT_W)) u_timer (
    .clock    (clock),
    .reset_n  (reset_n),
    .clear    (tmr_clear),
    .enable   (tmr_enable),
    .term_val (tmr_term),
    .at_term  (tmr_at_term)
  );

  always_comb begin
    state_d    = state_q;
    lt_d       = 1'b0;
    tmr_enable = 1'b0;
    tmr_term   = SETTLE_LAST;
    case (state_q)
      ST_IDLE: begin
`ifdef SEQ_DEBOUNCE_EN
        // Quiet window restarts on every request pulse and saturates at its end.
        tmr_enable = !config_changed && !tmr_at_term;
        if (!config_changed && tmr_at_term && (pending_mode_q != active_mode))
          state_d = ST_WAIT_FRAME;
`else
        if (pending_mode_q != active_mode)
          state_d = ST_WAIT_FRAME;
`endif
      end
      ST_WAIT_FRAME: begin
        if (frame_end)
          state_d = ST_REQ;
      end
      ST_REQ: begin
        if (pll_reconfig_req && pll_reconfig_ack)
          state_d = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        tmr_term   = LOCK_LAST;
        tmr_enable = 1'b1;
        if (pll_locked) begin
          state_d = ST_SETTLE;
        end else if (tmr_at_term) begin
          lt_d    = 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_SETTLE: begin
        tmr_enable = 1'b1;
        if (!pll_locked)
          state_d = ST_WAIT_LOCK;
        else if (tmr_at_term)
          state_d = ST_IDLE;
      end
      default: state_d = ST_REQ;
    endcase
  end

  // Every state change restarts the shared timer, so it never carries a stale count.
`ifdef SEQ_DEBOUNCE_EN
  assign tmr_clear = (state_d != state_q) || ((state_q == ST_IDLE) && config_changed);
`else
  assign tmr_clear = (state_d != state_q);
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= ST_REQ;
      pll_reconfig_req <= 1'b0;
      video_enable     <= 1'b0;
      lock_timeout     <= 1'b0;
      pll_mode         <= DEFAULT_FB_MODE;
      active_mode      <= DEFAULT_FB_MODE;
      pending_mode_q   <= DEFAULT_FB_MODE;
    end else begin
      state_q          <= state_d;
      pll_reconfig_req <= (state_d == ST_REQ);
      video_enable     <= (state_d == ST_IDLE) || (state_d == ST_WAIT_FRAME);
      lock_timeout     <= lt_d;
      if (config_changed)
        pending_mode_q <= legalize_mode(config_data);
      // pll_mode is only loaded at the frame boundary, so it is frozen for the whole handshake.
      if ((state_q == ST_WAIT_FRAME) && frame_end)
        pll_mode <= pending_mode_q;
      if ((state_q == ST_SETTLE) && (state_d == ST_IDLE))
        active_mode <= pll_mode;
    end
  end

  assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mode_switch_sequencer.sv
// Directed bench for mode_switch_sequencer: per-cycle compare against a countdown-style model.
module tb_mode_switch_sequencer;

  localparam int SETTLE = 8;
  localparam int LTO    = 16;
  localparam logic [7:0] M1080P = 8'h01, M1080I = 8'h02, M720P = 8'h03;
  localparam logic [7:0] M480P  = 8'h04, M480I  = 8'h05, MDEF  = 8'h04;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] config_data = 8'h00;
  logic       config_changed = 1'b0;
  logic       frame_end = 1'b0;
  logic       pll_reconfig_ack = 1'b0;
  logic       pll_locked = 1'b0;
  logic       pll_reconfig_req;
  logic [7:0] pll_mode;
  logic [7:0] active_mode;
  logic       video_enable;
  logic       busy;
  logic       lock_timeout;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  mode_switch_sequencer #(
    .SETTLE_CYCLES (SETTLE),
    .LOCK_TIMEOUT  (LTO),
    .CNT_W         (21)
  ) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .config_data      (config_data),
    .config_changed   (config_changed),
    .frame_end        (frame_end),
    .pll_reconfig_ack (pll_reconfig_ack),
    .pll_locked       (pll_locked),
    .pll_reconfig_req (pll_reconfig_req),
    .pll_mode         (pll_mode),
    .active_mode      (active_mode),
    .video_enable     (video_enable),
    .busy             (busy),
    .lock_timeout     (lock_timeout)
  );

  always #5 clock = ~clock;

  // Model: phase + cycles-remaining countdown, derived from the behavioural rules.
  localparam int PH_RUN = 0, PH_FRAME = 1, PH_PROG = 2, PH_LOCK = 3, PH_SETTLE = 4;
  int         ph;
  int         left;
  logic [7:0] m_pend, m_prog, m_act;
  logic       m_req, m_ven, m_lt;

  function automatic logic [7:0] legal(input logic [7:0] c);
    return (c >= 8'h01 && c <= 8'h05) ? c : MDEF;
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ph <= PH_PROG; left <= 0;
      m_pend <= MDEF; m_prog <= MDEF; m_act <= MDEF;
      m_req <= 1'b0; m_ven <= 1'b0; m_lt <= 1'b0;
    end else begin
      m_lt <= 1'b0;
      if (config_changed) m_pend <= legal(config_data);
      case (ph)
        PH_RUN:   if (m_pend != m_act) ph <= PH_FRAME;
        PH_FRAME: if (frame_end) begin
                    m_ven <= 1'b0; m_prog <= m_pend; ph <= PH_PROG; m_req <= 1'b1;
                  end
        PH_PROG:  if (m_req && pll_reconfig_ack) begin
                    m_req <= 1'b0; ph <= PH_LOCK; left <= LTO;
                  end else m_req <= 1'b1;
        PH_LOCK:  if (pll_locked) begin
                    ph <= PH_SETTLE; left <= SETTLE;
                  end else if (left == 1) begin
                    m_lt <= 1'b1; ph <= PH_PROG; m_req <= 1'b1;
                  end else left <= left - 1;
        PH_SETTLE: if (!pll_locked) begin
                    ph <= PH_LOCK; left <= LTO;
                  end else if (left == 1) begin
                    m_act <= m_prog; ph <= PH_RUN; m_ven <= 1'b1;
                  end else left <= left - 1;
        default: ;
      endcase
    end
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      cmp("req",          32'(pll_reconfig_req), 32'(m_req));
      cmp("pll_mode",     32'(pll_mode),         32'(m_prog));
      cmp("active_mode",  32'(active_mode),      32'(m_act));
      cmp("video_enable", 32'(video_enable),     32'(m_ven));
      cmp("busy",         32'(busy),             32'(ph != PH_RUN));
      cmp("lock_timeout", 32'(lock_timeout),     32'(m_lt));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  function automatic logic cond(input int which);
    case (which)
      0:       return video_enable === 1'b1;
      1:       return pll_reconfig_req === 1'b1;
      default: return lock_timeout === 1'b1;
    endcase
  endfunction

  // Counts edges until the selected output goes high; a missed bound reports as -1.
  task automatic wait_for(input int which, input string name, input int exp_n);
    int  n   = -1;
    bit  hit = 1'b0;
    for (int i = 1; i <= 200 && !hit; i++) begin
      tick(1);
      if (cond(which)) begin hit = 1'b1; n = i; end
    end
    cmp(name, 32'(n), 32'(exp_n));
  endtask

  task automatic request(input logic [7:0] code);
    config_data = code; config_changed = 1'b1;
    tick(1);
    config_changed = 1'b0;
  endtask

  task automatic frame_pulse();
    pll_locked = 1'b0; frame_end = 1'b1;
    tick(1);
    frame_end = 1'b0;
  endtask

  task automatic ack_pulse();
    pll_reconfig_ack = 1'b1;
    tick(1);
    pll_reconfig_ack = 1'b0;
  endtask

  // Lock is registered on one edge, then SETTLE edges follow before video returns.
  task automatic lock_settle(input string name);
    pll_locked = 1'b1;
    wait_for(0, name, 1 + SETTLE);
  endtask

  initial begin
    tick(3);
    chk_en = 1'b1;
    cmp("rst_req",  32'(pll_reconfig_req), 32'd0);
    cmp("rst_ven",  32'(video_enable),     32'd0);
    cmp("rst_busy", 32'(busy),             32'd1);
    cmp("rst_lt",   32'(lock_timeout),     32'd0);
    cmp("rst_pll",  32'(pll_mode),         32'(MDEF));
    cmp("rst_act",  32'(active_mode),      32'(MDEF));

    // Power-up programming of the default mode
    reset_n = 1'b1;
    wait_for(1, "pwr_req_lat", 1);
    tick(2);
    cmp("pwr_pll", 32'(pll_mode), 32'(MDEF));
    ack_pulse();
    tick(4);
    lock_settle("pwr_ven_lat");
    cmp("pwr_busy", 32'(busy), 32'd0);

    // Move to 720p, then the normal 720p -> 1080p switch
    request(M720P); tick(2); frame_pulse(); ack_pulse(); lock_settle("to720_ven");
    cmp("to720_act", 32'(active_mode), 32'(M720P));
    request(M1080P);
    tick(3);
    cmp("sw_ven_held", 32'(video_enable), 32'd1);
    cmp("sw_busy",     32'(busy),         32'd1);
    frame_pulse();
    cmp("sw_ven_low",  32'(video_enable), 32'd0);
    cmp("sw_req",      32'(pll_reconfig_req), 32'd1);
    cmp("sw_pll",      32'(pll_mode),     32'(M1080P));
    ack_pulse(); tick(2); lock_settle("sw_ven_lat");
    cmp("sw_act", 32'(active_mode), 32'(M1080P));

    // Illegal code falls back to the default mode; repeating it is a no-op
    request(8'hAB); tick(2); frame_pulse();
    cmp("ill_pll", 32'(pll_mode), 32'(MDEF));
    ack_pulse(); lock_settle("ill_ven_lat");
    request(8'hAB); tick(4);
    cmp("ill_noop_busy", 32'(busy), 32'd0);
    cmp("ill_noop_ven",  32'(video_enable), 32'd1);

    // New request while waiting for lock of 720p
    request(M720P); tick(2); frame_pulse(); ack_pulse();
    tick(2); request(M480P); tick(2);
    cmp("mid_pll_frozen", 32'(pll_mode), 32'(M720P));
    lock_settle("mid_ven_lat");
    cmp("mid_act", 32'(active_mode), 32'(M720P));
    tick(2);
    cmp("mid_restart_busy", 32'(busy), 32'd1);
    frame_pulse();
    cmp("mid_pll_second", 32'(pll_mode), 32'(M480P));
    ack_pulse(); lock_settle("mid2_ven_lat");
    cmp("mid2_act", 32'(active_mode), 32'(M480P));

    // Lock timeout with the PLL never locking
    request(M1080I); tick(2); frame_pulse(); ack_pulse();
    wait_for(2, "to_lat", LTO);
    cmp("to_req", 32'(pll_reconfig_req), 32'd1);
    cmp("to_pll", 32'(pll_mode), 32'(M1080I));
    ack_pulse(); lock_settle("to_ven_lat");
    cmp("to_act", 32'(active_mode), 32'(M1080I));

    // Lock loss in SETTLE restarts the full settle count
    request(M480I); tick(2); frame_pulse(); ack_pulse();
    pll_locked = 1'b1; tick(4);
    pll_locked = 1'b0; tick(1);
    cmp("loss_busy", 32'(busy), 32'd1);
    cmp("loss_ven",  32'(video_enable), 32'd0);
    lock_settle("loss_ven_lat");
    cmp("loss_act", 32'(active_mode), 32'(M480I));

    // Reset while req is high drops it without waiting for a clock edge
    request(M720P); tick(2); frame_pulse();
    cmp("rst2_req_before", 32'(pll_reconfig_req), 32'd1);
    reset_n = 1'b0;
    #1;
    cmp("rst2_req_async", 32'(pll_reconfig_req), 32'd0);
    cmp("rst2_pll",       32'(pll_mode), 32'(MDEF));
    tick(2);
    reset_n = 1'b1;
    wait_for(1, "rst2_req_lat", 1);
    cmp("rst2_pll_req", 32'(pll_mode), 32'(MDEF));
    ack_pulse(); tick(4); lock_settle("rst2_ven_lat");
    cmp("rst2_act", 32'(active_mode), 32'(MDEF));

    tick(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, bad=%0d", bad);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mode_switch_sequencer.md
Name: mode_switch_sequencer

Overview:
- Consumer of the switch-configuration outputs (config_data mode byte plus config_changed pulse); turns a requested video mode into a safe, frame-aligned mode switch.
- Blanks video at a frame boundary, hands the new mode to the PLL/timing reconfiguration logic over a req/ack handshake, waits for PLL lock plus a settle time, then re-enables video.
- Sits between the configuration block and the PLL reconfig / video timing generator.

Parameters:
- SETTLE_CYCLES, 1024: cycles of stable pll_locked required after lock before video is re-enabled; minimum 1.
- LOCK_TIMEOUT, 1048576: cycles allowed in WAIT_LOCK before the request is re-issued; minimum 2.
- CNT_W, 21: width of the shared cycle counter; must hold max(SETTLE_CYCLES, LOCK_TIMEOUT).

Ports:
- clock, in, 1: system clock.
- reset_n, in, 1: asynchronous active-low reset.
- config_data, in, 8: requested mode code (MODE_* values).
- config_changed, in, 1: one-cycle pulse when config_data changes.
- frame_end, in, 1: one-cycle pulse on the last pixel of each frame.
- pll_reconfig_ack, in, 1: PLL reconfig logic has accepted pll_mode.
- pll_locked, in, 1: PLL lock status (already synchronised).
- pll_reconfig_req, out, 1: reconfiguration request, held until ack.
- pll_mode, out, 8: mode being programmed; stable while req is high.
- active_mode, out, 8: mode currently driven to the video path.
- video_enable, out, 1: video output enable.
- busy, out, 1: high in every state except IDLE.
- lock_timeout, out, 1: one-cycle pulse on every lock timeout.

Behaviour:
- Reset values:
  - pll_reconfig_req=0, video_enable=0, busy=1, lock_timeout=0.
  - active_mode=pll_mode=DEFAULT_FB_MODE; pending_mode=DEFAULT_FB_MODE.
  - State=REQ, so the PLL is programmed once after every reset.
- Mode legality: a config_data value not in {MODE_1080p, MODE_1080i, MODE_720p, MODE_480p, MODE_480i} is replaced by DEFAULT_FB_MODE when captured.
- Capture: in any state, config_changed=1 loads pending_mode from config_data on the same edge. The latest pulse wins.
- States:
  - IDLE:
    - video_enable=1, busy=0.
    - If pending_mode != active_mode, go to WAIT_FRAME (registered; busy rises the next cycle).
    - A config_changed pulse that restores the active mode causes no transition.
  - WAIT_FRAME:
    - Stay until frame_end=1.
    - On that edge: video_enable<=0, pll_mode<=pending_mode, go to REQ.
  - REQ:
    - pll_reconfig_req=1.
    - On pll_reconfig_ack=1: req<=0, counter cleared, go to WAIT_LOCK.
    - Ack seen in the same cycle req first rises counts.
  - WAIT_LOCK:
    - Counter increments each cycle.
    - If pll_locked=1, clear the counter and go to SETTLE.
    - Else if counter==LOCK_TIMEOUT-1: pulse lock_timeout, go to REQ with the same pll_mode.
  - SETTLE:
    - If pll_locked drops, clear the counter and return to WAIT_LOCK.
    - If counter==SETTLE_CYCLES-1: active_mode<=pll_mode, go to IDLE.
    - video_enable=1 from the IDLE cycle onward.
- Mode change mid-sequence:
  - The in-flight pll_mode is never altered while req is high or while awaiting lock.
  - After reaching IDLE, the standard pending/active compare restarts the sequence.
  - The restart does not wait for an extra frame beyond the normal WAIT_FRAME.
- Reset asserted mid-sequence: immediate return to reset values, req dropped asynchronously.
- Counter never wraps; it is cleared on every state entry that uses it.

Optional Feature:
- Macro: SEQ_DEBOUNCE_EN.
- Defined:
  - IDLE leaves only after pending_mode has been unchanged, with no config_changed pulse, for SETTLE_CYCLES consecutive cycles.
  - Any pulse during that window restarts it.
  - busy stays 0 during debounce.
- Undefined: behaviour as above; no debounce counter is synthesised.

Decomposition:
- MODE_* codes and DEFAULT_FB_MODE stay in the shared defines.v. Add a MODE_IS_VALID macro there for the legality check.
- State encodings are local constants of this module.
- One natural sub-module: sequencer_timer, a CNT_W-bit clear/enable counter with terminal-compare output. It is shared by WAIT_LOCK and SETTLE, plus the debounce timer when SEQ_DEBOUNCE_EN is defined.

Test Plan:
- Power-up, SETTLE_CYCLES=8:
  - Release reset; ack after 3 cycles; pll_locked high 5 cycles later.
  - Expect pll_mode=DEFAULT_FB_MODE.
  - Expect video_enable rising 8 cycles after lock, and busy=0.
- Normal switch:
  - From IDLE with active=MODE_720p, pulse config_changed with MODE_1080p.
  - Expect video_enable held until frame_end, then low.
  - Expect req with pll_mode=MODE_1080p, and active_mode=MODE_1080p after settle.
- Illegal code:
  - config_data=8'hAB with config_changed.
  - Expect the sequence to run with pll_mode=DEFAULT_FB_MODE.
  - If active already equals DEFAULT_FB_MODE, no transition.
- Change during WAIT_LOCK:
  - Request MODE_480p mid-lock of MODE_720p.
  - Expect the 720p sequence to complete unchanged, then a second sequence programming MODE_480p at the next frame_end.
- Lock timeout, LOCK_TIMEOUT=16:
  - Keep pll_locked=0.
  - Expect a lock_timeout pulse 16 cycles after ack, req reasserted with the same pll_mode.
  - Then lock, settle, and enable.
- Lock loss and reset:
  - Drop pll_locked during SETTLE: expect return to WAIT_LOCK and the settle count restarting.
  - Assert reset_n low while req=1: expect req=0 immediately and a restart from REQ with DEFAULT_FB_MODE.
